// File: rtl/ysyx_22051013_mem_arbiter_pkg.sv
// Shared encodings for the icache/dcache memory arbiter.
package ysyx_22051013_mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GNT_I = 2'd1;
  localparam logic [1:0] ARB_GNT_D = 2'd2;
  localparam logic [1:0] ARB_GAP   = 2'd3;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/ysyx_22051013_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module ysyx_22051013_rr_pick2
  import ysyx_22051013_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == REQ_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ysyx_22051013_mem_arbiter.sv
// Shares the AXI bridge port between the icache refill path and the dcache.
module ysyx_22051013_mem_arbiter
  import ysyx_22051013_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_ena,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [7:0]        d_wstrb,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  logic [1:0]        mask;
  logic              last_grant;
  logic [TW-1:0]     timer;
  logic              err_q;
  logic [1:0]        req_m;
  logic [1:0]        grant;
  logic              in_gnt;
  logic              timeout_hit;
  logic              done_evt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wstrb_q;

  // Requests are only considered in IDLE; GAP swallows both so a late-dropping requester is not re-served.
  assign req_m = (state == ARB_IDLE) ? ({d_ena, i_ena} & ~mask) : 2'b00;

  ysyx_22051013_rr_pick2 u_pick (
    .req   (req_m),
    .last  (last_grant),
    .grant (grant)
  );

  assign in_gnt      = (state == ARB_GNT_I) || (state == ARB_GNT_D);
  assign timeout_hit = in_gnt && !mem_done && (timer == TW'(TIMEOUT));
  assign done_evt    = in_gnt && (mem_done || timeout_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      mask       <= 2'b00;
      last_grant <= REQ_D;
      timer      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          timer <= '0;
          if (grant[REQ_I]) begin
            state      <= ARB_GNT_I;
            last_grant <= REQ_I;
            timer      <= TW'(1);
          end else if (grant[REQ_D]) begin
            state      <= ARB_GNT_D;
            last_grant <= REQ_D;
            timer      <= TW'(1);
          end
        end
        ARB_GNT_I, ARB_GNT_D: begin
          if (done_evt) begin
            state <= ARB_GAP;
            mask  <= (state == ARB_GNT_I) ? 2'b01 : 2'b10;
            timer <= '0;
            if (timeout_hit) err_q <= 1'b1;
          end else if (timer != TW'(TIMEOUT)) begin
            timer <= timer + TW'(1);
          end
        end
        ARB_GAP: begin
          state <= ARB_IDLE;
          mask  <= 2'b00;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Request fields are captured once at grant; outputs are gated so their reset value is irrelevant.
  always_ff @(posedge clk) begin
    if ((state == ARB_IDLE) && (grant != 2'b00)) begin
      addr_q  <= grant[REQ_I] ? i_addr : d_addr;
      we_q    <= grant[REQ_D] & d_we;
      wdata_q <= d_wdata;
      wstrb_q <= d_wstrb;
    end
  end

  assign mem_req   = in_gnt;
  assign mem_we    = (state == ARB_GNT_D) & we_q;
  assign mem_addr  = in_gnt ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign mem_wstrb = mem_we ? wstrb_q : 8'h00;

  assign i_valid = done_evt && (state == ARB_GNT_I);
  assign d_valid = done_evt && (state == ARB_GNT_D);
  assign i_rdata = (i_valid && !timeout_hit) ? mem_rdata : '0;
  assign d_rdata = (d_valid && !timeout_hit) ? mem_rdata : '0;
  assign err     = err_q | timeout_hit;

endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// Bench for the icache/dcache memory arbiter: vector table plus scoreboard of expected bridge transactions.
module tb_ysyx_22051013_mem_arbiter;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ena;
  logic [63:0] i_addr;
  logic        i_valid;
  logic [63:0] i_rdata;
  logic        d_ena;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wstrb;
  logic        d_valid;
  logic [63:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_done;
  logic [63:0] mem_rdata;
  logic        err;

  always #5 clk = ~clk;

  ysyx_22051013_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_ena(i_ena), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_ena(d_ena), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    int          lat;
  } vec_t;

  vec_t exp_q[$];
  vec_t vt[6];
  int   nvec = 0;
  int   nerr = 0;
  logic tb_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    if (v.is_d) begin
      d_ena = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
    end else begin
      i_ena = 1'b1; i_addr = v.addr;
    end
    exp_q.push_back(v);
  endtask

  // Waits for the next grant, checks it against the scoreboard head and completes it.
  task automatic serve(input bit drop, input bit scramble, output int waited);
    vec_t        e;
    logic        xwe;
    logic [63:0] xwd;
    logic [7:0]  xst;
    waited = 0;
    do begin
      tick(); #1; waited++;
    end while (!mem_req && waited < 40);
    check("grant_seen", mem_req, 1);
    if (exp_q.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL scoreboard_empty: got grant, expected none");
      return;
    end
    e = exp_q.pop_front();
    if (!mem_req) return;
    xwe = e.is_d & e.we;
    xwd = xwe ? e.wdata : 64'h0;
    xst = xwe ? e.wstrb : 8'h00;
    check("mem_addr", mem_addr, e.addr);
    check("mem_we", mem_we, xwe);
    check("mem_wdata", mem_wdata, xwd);
    check("mem_wstrb", mem_wstrb, xst);
    if (scramble) begin
      if (e.is_d) begin
        d_addr = ~d_addr; d_we = ~d_we; d_wdata = ~d_wdata; d_wstrb = ~d_wstrb;
      end else begin
        i_addr = ~i_addr;
      end
    end
    repeat (e.lat) tick();
    mem_done = 1'b1; mem_rdata = e.rdata; #1;
    check("mem_addr_hold", mem_addr, e.addr);
    check("mem_we_hold", mem_we, xwe);
    check("mem_req_at_done", mem_req, 1);
    check(e.is_d ? "d_valid" : "i_valid", e.is_d ? d_valid : i_valid, 1);
    check(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
    check(e.is_d ? "i_valid_twin" : "d_valid_twin", e.is_d ? i_valid : d_valid, 0);
    check(e.is_d ? "i_rdata_twin" : "d_rdata_twin", e.is_d ? i_rdata : d_rdata, 0);
    tb_last = e.is_d;
    tick();
    mem_done = 1'b0; mem_rdata = 64'h5a5a_5a5a_5a5a_5a5a;
    if (drop) begin
      if (e.is_d) d_ena = 1'b0; else i_ena = 1'b0;
    end
    #1;
    check("mem_req_drop", mem_req, 0);
    check("valid_after_done", {i_valid, d_valid}, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   w;
    int   cnt;
    vec_t v;

    vt[0] = '{1'b0, 1'b0, 64'h8000_0100, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 0};
    vt[1] = '{1'b1, 1'b1, 64'h8000_0200, 64'hcafe_f00d_0bad_beef, 8'hf0, 64'h0, 2};
    vt[2] = '{1'b1, 1'b0, 64'h8000_0300, 64'hffff_ffff_ffff_ffff, 8'hff, 64'hfeed_face_0000_0001, 1};
    vt[3] = '{1'b0, 1'b0, 64'hffff_ffff_ffff_fff8, 64'h0, 8'h00, 64'hffff_ffff_ffff_ffff, 5};
    vt[4] = '{1'b1, 1'b1, 64'h0000_0000_0000_0008, 64'h0123_4567_89ab_cdef, 8'h01, 64'h0, 0};
    vt[5] = '{1'b1, 1'b1, 64'h8000_0400, 64'h8765_4321_0fed_cba9, 8'hff, 64'h0, 3};

    rst = 1'b1; i_ena = 0; i_addr = 0; d_ena = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0; mem_done = 0; mem_rdata = 64'h5a5a_5a5a_5a5a_5a5a;
    tb_last = 1'b1;
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_valids", {i_valid, d_valid}, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", i_rdata | d_rdata, 0);
    tick(); tick();
    rst = 1'b0;

    // Simultaneous requests straight after reset: icache first, then the dcache write.
    v = '{1'b0, 1'b0, 64'h8000_0040, 64'h0, 8'h00, 64'h0aaa, 2};
    issue(v);
    v = '{1'b1, 1'b1, 64'h8000_1000, 64'hdead_beef, 8'h0f, 64'h0, 1};
    issue(v);
    serve(1, 0, w);
    check("tie_latency", w, 1);
    serve(1, 0, w);

    // Lone icache read with exact timing, then a stale request held through GAP.
    tick();
    v = '{1'b0, 1'b0, 64'h8000_0008, 64'h0, 8'h00, 64'h1234, 3};
    issue(v);
    serve(0, 0, w);
    check("lone_latency", w, 1);
    tick();
    i_ena = 1'b0; mem_done = 1'b1; #1;
    check("idle_done_ignored", {i_valid, d_valid}, 0);
    check("stale_absorbed0", mem_req, 0);
    tick();
    mem_done = 1'b0; #1;
    check("stale_absorbed1", mem_req, 0);
    tick(); #1;
    check("stale_absorbed2", mem_req, 0);

    for (int k = 0; k < 6; k++) begin
      issue(vt[k]);
      serve(1, 1, w);
      check("vec_latency", w, 1);
      tick();
    end

    // Both requesters hold their requests: grants must alternate.
    i_ena = 1'b1; i_addr = 64'h8000_2000;
    d_ena = 1'b1; d_we = 1'b0; d_addr = 64'h8000_3000; d_wdata = 0; d_wstrb = 0;
    for (int k = 0; k < 10; k++) begin
      v.is_d  = ~tb_last;
      v.we    = 1'b0;
      v.addr  = v.is_d ? 64'h8000_3000 : 64'h8000_2000;
      v.wdata = 0; v.wstrb = 0;
      v.rdata = 64'h100 + 64'(k);
      v.lat   = k % 3;
      exp_q.push_back(v);
      serve(0, 0, w);
    end
    tick();
    i_ena = 1'b0; d_ena = 1'b0; #1;
    check("err_before_timeout", err, 0);
    tick();

    // Dcache grant that never completes.
    d_ena = 1'b1; d_we = 1'b0; d_addr = 64'h8000_4000; mem_rdata = 64'hffff;
    cnt = 0;
    do begin
      tick(); #1; cnt++;
    end while (!d_valid && cnt < TIMEOUT + 20);
    check("timeout_cycles", cnt, TIMEOUT);
    check("timeout_err", err, 1);
    check("timeout_d_rdata", d_rdata, 0);
    check("timeout_i_valid", i_valid, 0);
    tick();
    d_ena = 1'b0; #1;
    check("timeout_mem_req_drop", mem_req, 0);
    check("err_sticky", err, 1);
    tb_last = 1'b1;
    tick();
    v = '{1'b0, 1'b0, 64'h8000_4008, 64'h0, 8'h00, 64'h7777, 1};
    issue(v);
    serve(1, 0, w);
    check("err_sticky_after", err, 1);

    // Reset while the dcache owns the bridge.
    tick();
    d_ena = 1'b1; d_we = 1'b1; d_addr = 64'h8000_5000; d_wdata = 64'h55; d_wstrb = 8'h3;
    cnt = 0;
    do begin
      tick(); #1; cnt++;
    end while (!mem_req && cnt < 40);
    check("rst_mid_grant", mem_req, 1);
    tick();
    rst = 1'b1; mem_done = 1'b1; mem_rdata = 64'h99; #1;
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_d_valid", d_valid, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_mem_we", mem_we, 0);
    tick();
    rst = 1'b0; mem_done = 1'b0; d_ena = 1'b0; tb_last = 1'b1;
    v = '{1'b0, 1'b0, 64'h8000_6000, 64'h0, 8'h00, 64'habcd, 1};
    issue(v);
    serve(1, 0, w);
    check("post_rst_latency", w, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
